uart_led_pwm_regs: RTL



---
 rtl/uart_led_pwm_regs.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_led_pwm_regs.sv
`default_nettype none
// ============================================================================
// Module   : uart_led_pwm_regs
// Purpose  : Byte-stream command parser ('W' addr data / 'R' addr) feeding a
//            register file of per-channel 8-bit PWM duty registers plus CTRL
//            (0x80) and PRESCALE (0x81). Drives NUM_CHANNELS PWM LED outputs
//            and returns ACK/NAK/read data to the UART transmitter.
// Options  : `define UART_LED_PWM_TIMEOUT_EN enables the inter-byte timeout.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module uart_led_pwm_regs #(
    parameter int         NUM_CHANNELS   = 8,
    parameter logic [7:0] PRESCALE_RESET = 8'd0,
    parameter int         TIMEOUT_CYCLES = 1562500
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx_valid,
    input  logic [7:0]              i_rx_byte,
    output logic                    o_rx_ready,
    output logic                    o_tx_valid,
    output logic [7:0]              o_tx_byte,
    input  logic                    i_tx_ready,
    output logic [NUM_CHANNELS-1:0] o_led,
    output logic                    o_mem_reset
);

    // Parser states
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    // Protocol bytes and special register addresses
    localparam logic [7:0] c_CMD_W     = 8'h57;
    localparam logic [7:0] c_CMD_R     = 8'h52;
    localparam logic [7:0] c_ACK       = 8'h06;
    localparam logic [7:0] c_NAK       = 8'h15;
    localparam logic [7:0] c_ADDR_CTRL = 8'h80;
    localparam logic [7:0] c_ADDR_PRE  = 8'h81;

    logic [1:0]              r_state;
    logic                    r_is_write;
    logic [7:0]              r_addr;
    logic [7:0]              r_resp;
    logic [7:0]              r_duty [NUM_CHANNELS];
    logic                    r_en;
    logic                    r_ovf;
    logic [7:0]              r_prescale;
    logic [7:0]              r_tick_cnt;
    logic [7:0]              r_pwm_cnt;
    logic [NUM_CHANNELS-1:0] r_led;
    logic                    r_mem_reset;

    logic       w_drop;
    logic       w_rd_valid;
    logic [7:0] w_rd_data;
    logic       w_wr_valid;
    logic       w_write;
    logic       w_ctrl_wr;
    logic       w_pre_wr;
    logic       w_soft;
    logic       w_tick;
    logic       w_timeout;

    // A byte strobed while a response is pending cannot be accepted
    assign w_drop = i_rx_valid && (r_state == c_RESP);

    // Read decode works on the incoming address byte so the value can be
    // captured in the same cycle the address arrives
    always_comb begin
        w_rd_valid = 1'b0;
        w_rd_data  = 8'h00;
        if (i_rx_byte == c_ADDR_CTRL) begin
            w_rd_valid = 1'b1;
            w_rd_data  = {r_ovf, 6'b000000, r_en};
        end else if (i_rx_byte == c_ADDR_PRE) begin
            w_rd_valid = 1'b1;
            w_rd_data  = r_prescale;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (i_rx_byte == 8'(i)) begin
                    w_rd_valid = 1'b1;
                    w_rd_data  = r_duty[i];
                end
            end
        end
    end

    // Write decode uses the address latched during the ADDR phase
    assign w_wr_valid = (r_addr == c_ADDR_CTRL) || (r_addr == c_ADDR_PRE) ||
                        ({24'd0, r_addr} < 32'(NUM_CHANNELS));
    assign w_write    = (r_state == c_DATA) && i_rx_valid && !w_timeout && w_wr_valid;
    assign w_ctrl_wr  = w_write && (r_addr == c_ADDR_CTRL);
    assign w_pre_wr   = w_write && (r_addr == c_ADDR_PRE);
    assign w_soft     = w_ctrl_wr && i_rx_byte[1];

`ifdef UART_LED_PWM_TIMEOUT_EN
    localparam int c_GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_GAP_W-1:0] r_gap;

    // Timeout fires on the idle cycle that would bring the gap to TIMEOUT_CYCLES
    assign w_timeout = ((r_state == c_ADDR) || (r_state == c_DATA)) && !i_rx_valid &&
                       (r_gap == c_GAP_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter between bytes of one command
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gap <= '0;
        end else if (i_rx_valid || w_timeout ||
                     !((r_state == c_ADDR) || (r_state == c_DATA))) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Command parser FSM and response capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= c_IDLE;
            r_is_write <= 1'b0;
            r_addr     <= 8'h00;
            r_resp     <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_byte == c_CMD_W) begin
                            r_is_write <= 1'b1;
                            r_state    <= c_ADDR;
                        end else if (i_rx_byte == c_CMD_R) begin
                            r_is_write <= 1'b0;
                            r_state    <= c_ADDR;
                        end else begin
                            r_resp  <= c_NAK;
                            r_state <= c_RESP;
                        end
                    end
                end
                c_ADDR: begin
                    if (w_timeout) begin
                        r_state <= c_IDLE;
                    end else if (i_rx_valid) begin
                        r_addr <= i_rx_byte;
                        if (r_is_write) begin
                            r_state <= c_DATA;
                        end else begin
                            r_resp  <= w_rd_valid ? w_rd_data : c_NAK;
                            r_state <= c_RESP;
                        end
                    end
                end
                c_DATA: begin
                    if (w_timeout) begin
                        r_state <= c_IDLE;
                    end else if (i_rx_valid) begin
                        r_resp  <= w_wr_valid ? c_ACK : c_NAK;
                        r_state <= c_RESP;
                    end
                end
                default: begin
                    if (i_tx_ready) begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    // Duty registers: written by the parser, cleared by soft reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_duty[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_soft) begin
                    r_duty[i] <= 8'h00;
                end else if (w_write && (r_addr == 8'(i))) begin
                    r_duty[i] <= i_rx_byte;
                end
            end
        end
    end

    // CTRL / PRESCALE registers and the soft-reset pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en        <= 1'b1;
            r_ovf       <= 1'b0;
            r_prescale  <= PRESCALE_RESET;
            r_mem_reset <= 1'b0;
        end else begin
            r_mem_reset <= w_soft;
            if (w_ctrl_wr) begin
                r_en <= i_rx_byte[0];
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ctrl_wr && i_rx_byte[7]) begin
                r_ovf <= 1'b0;
            end
            if (w_pre_wr) begin
                r_prescale <= i_rx_byte;
            end
        end
    end

    // Wrap with >= so a prescale lowered below the current count recovers at once
    assign w_tick = (r_tick_cnt >= r_prescale);

    // Prescale tick counter and 8-bit PWM phase counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick_cnt <= 8'h00;
            r_pwm_cnt  <= 8'h00;
        end else begin
            r_tick_cnt <= w_tick ? 8'h00 : r_tick_cnt + 8'h01;
            if (w_soft) begin
                r_pwm_cnt <= 8'h00;
            end else if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'h01;
            end
        end
    end

    // Registered per-channel compare
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_led
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_led[gi] <= 1'b0;
            end else begin
                r_led[gi] <= r_en && (r_pwm_cnt < r_duty[gi]);
            end
        end
    end

    assign o_rx_ready  = (r_state != c_RESP);
    assign o_tx_valid  = (r_state == c_RESP);
    assign o_tx_byte   = r_resp;
    assign o_led       = r_led;
    assign o_mem_reset = r_mem_reset;

endmodule
`default_nettype wire
